// File: rtl/crc_stream.sv
// Streaming CRC engine: forwards each accepted beat one cycle later and either reports the
// finished CRC alongside the last beat or, in check mode, turns a bad frame into an abort.
module crc_stream #(
  parameter int unsigned         DW           = 64,
  parameter int unsigned         CRC_BITS     = 32,
  parameter logic [CRC_BITS-1:0] POLYNOMIAL   = 32'hedb88320,
  parameter logic [CRC_BITS-1:0] INIT         = '1,
  parameter logic [CRC_BITS-1:0] RESIDUE      = 32'hdebb20e3,
  parameter bit                  OPT_CHECK    = 1'b0,
  parameter bit                  OPT_LOWPOWER = 1'b0,
  localparam int unsigned        NB           = DW / 8,
  localparam int unsigned        BW           = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                S_AXIN_VALID,
  output logic                S_AXIN_READY,
  input  logic [DW-1:0]       S_AXIN_DATA,
  input  logic [BW-1:0]       S_AXIN_BYTES,
  input  logic                S_AXIN_LAST,
  input  logic                S_AXIN_ABORT,
  output logic                M_AXIN_VALID,
  input  logic                M_AXIN_READY,
  output logic [DW-1:0]       M_AXIN_DATA,
  output logic [BW-1:0]       M_AXIN_BYTES,
  output logic                M_AXIN_LAST,
  output logic                M_AXIN_ABORT,
  output logic [CRC_BITS-1:0] o_crc,
  output logic                o_err
);

  logic [CRC_BITS-1:0] crc_q, crc_d;
  logic                midpkt_q, midpkt_d;
  logic                m_valid_q, m_valid_d;
  logic [DW-1:0]       m_data_q, m_data_d;
  logic [BW-1:0]       m_bytes_q, m_bytes_d;
  logic                m_last_q, m_last_d;
  logic                m_abort_q, m_abort_d;
  logic [CRC_BITS-1:0] crc_out_q, crc_out_d;
  logic                err_q, err_d;

  logic [CRC_BITS-1:0] stage [NB];
  logic [CRC_BITS-1:0] next_crc;
  logic [BW-1:0]       sel;
  logic                accept, abort_evt, bad_last, fwd;

  // stage[k] is the register after consuming bytes 0..k of the current beat
  always_comb begin
    logic [CRC_BITS-1:0] c;
    stage = '{default: '0};
    c = crc_q;
    for (int k = 0; k < int'(NB); k++) begin
      for (int b = 0; b < 8; b++) begin
        if (c[0] ^ S_AXIN_DATA[8*k+b]) c = (c >> 1) ^ POLYNOMIAL;
        else                           c = c >> 1;
      end
      stage[k] = c;
    end
  end

  always_comb begin
    sel = BW'(NB - 1);
    if (S_AXIN_LAST && (S_AXIN_BYTES != '0)) sel = S_AXIN_BYTES - BW'(1);
  end

  assign next_crc     = stage[sel];
  assign S_AXIN_READY = !m_valid_q || M_AXIN_READY;
  assign accept       = S_AXIN_VALID && S_AXIN_READY;
  assign abort_evt    = S_AXIN_ABORT && (midpkt_q || accept);
  assign bad_last     = OPT_CHECK && accept && !abort_evt && S_AXIN_LAST && (next_crc != RESIDUE);
  assign fwd          = accept && !abort_evt && !bad_last;

  always_comb begin
    crc_d     = crc_q;
    midpkt_d  = midpkt_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_bytes_d = m_bytes_q;
    m_last_d  = m_last_q;
    m_abort_d = m_abort_q;
    crc_out_d = crc_out_q;
    err_d     = 1'b0;

    if (abort_evt) begin
      crc_d    = INIT;
      midpkt_d = 1'b0;
    end else if (accept) begin
      crc_d    = S_AXIN_LAST ? INIT : next_crc;
      midpkt_d = !S_AXIN_LAST;
    end

    if (!m_valid_q || M_AXIN_READY) m_abort_d = 1'b0;
    if (M_AXIN_READY)               m_valid_d = 1'b0;

    if (fwd) begin
      m_valid_d = 1'b1;
      m_data_d  = S_AXIN_DATA;
      m_bytes_d = S_AXIN_BYTES;
      m_last_d  = S_AXIN_LAST;
      if (S_AXIN_LAST) crc_out_d = ~next_crc;
    end

    // An abort only goes downstream once part of the packet is already out there;
    // any beat still held in the output register is dropped with it.
    if ((abort_evt && midpkt_q) || bad_last) begin
      m_abort_d = 1'b1;
      m_valid_d = 1'b0;
    end
    if (bad_last) err_d = 1'b1;

    if (OPT_LOWPOWER && !m_valid_d) begin
      m_data_d  = '0;
      m_bytes_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      crc_q     <= INIT;
      midpkt_q  <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_bytes_q <= '0;
      m_last_q  <= 1'b0;
      m_abort_q <= 1'b0;
      crc_out_q <= '0;
      err_q     <= 1'b0;
    end else begin
      crc_q     <= crc_d;
      midpkt_q  <= midpkt_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_bytes_q <= m_bytes_d;
      m_last_q  <= m_last_d;
      m_abort_q <= m_abort_d;
      crc_out_q <= crc_out_d;
      err_q     <= err_d;
    end
  end

  assign M_AXIN_VALID = m_valid_q;
  assign M_AXIN_DATA  = m_data_q;
  assign M_AXIN_BYTES = m_bytes_q;
  assign M_AXIN_LAST  = m_last_q;
  assign M_AXIN_ABORT = m_abort_q;
  assign o_crc        = crc_out_q;
  assign o_err        = OPT_CHECK ? err_q : 1'b0;

endmodule

// File: tb/tb_crc_stream.sv
// Scoreboard bench for crc_stream: one generate-mode and one check-mode instance, DW=64.
module tb_crc_stream;

  typedef struct packed {
    logic v; logic [63:0] d; logic [2:0] b; logic l; logic a; logic r;
  } stim_t;
  typedef struct packed {
    logic [63:0] d; logic [2:0] b; logic l; logic a; logic e; logic [31:0] c;
  } ev_t;

  localparam logic [31:0] Golden = 32'hcbf43926;
  localparam logic [63:0] D1     = 64'h3837363534333231;  // "12345678"
  localparam logic [63:0] D2     = 64'ha5a5a5a5a5a5a539;  // "9" plus ignored garbage

  logic clk = 1'b0;
  logic rst;
  logic g_s_valid, g_s_ready, g_s_last, g_s_abort, g_m_valid, g_m_ready, g_m_last, g_m_abort;
  logic c_s_valid, c_s_ready, c_s_last, c_s_abort, c_m_valid, c_m_ready, c_m_last, c_m_abort;
  logic [63:0] g_s_data, g_m_data, c_s_data, c_m_data;
  logic [2:0]  g_s_bytes, g_m_bytes, c_s_bytes, c_m_bytes;
  logic [31:0] g_crc, c_crc;
  logic        g_err, c_err;

  int    n_checks = 0;
  int    n_fail   = 0;
  ev_t   g_q[$];
  ev_t   c_q[$];
  stim_t bp_q[$];

  always #5 clk = ~clk;

  crc_stream #(.DW(64), .OPT_CHECK(1'b0)) u_gen (
    .i_clk(clk), .i_reset(rst),
    .S_AXIN_VALID(g_s_valid), .S_AXIN_READY(g_s_ready), .S_AXIN_DATA(g_s_data),
    .S_AXIN_BYTES(g_s_bytes), .S_AXIN_LAST(g_s_last), .S_AXIN_ABORT(g_s_abort),
    .M_AXIN_VALID(g_m_valid), .M_AXIN_READY(g_m_ready), .M_AXIN_DATA(g_m_data),
    .M_AXIN_BYTES(g_m_bytes), .M_AXIN_LAST(g_m_last), .M_AXIN_ABORT(g_m_abort),
    .o_crc(g_crc), .o_err(g_err)
  );

  crc_stream #(.DW(64), .OPT_CHECK(1'b1)) u_chk (
    .i_clk(clk), .i_reset(rst),
    .S_AXIN_VALID(c_s_valid), .S_AXIN_READY(c_s_ready), .S_AXIN_DATA(c_s_data),
    .S_AXIN_BYTES(c_s_bytes), .S_AXIN_LAST(c_s_last), .S_AXIN_ABORT(c_s_abort),
    .M_AXIN_VALID(c_m_valid), .M_AXIN_READY(c_m_ready), .M_AXIN_DATA(c_m_data),
    .M_AXIN_BYTES(c_m_bytes), .M_AXIN_LAST(c_m_last), .M_AXIN_ABORT(c_m_abort),
    .o_crc(c_crc), .o_err(c_err)
  );

  function automatic stim_t mk_stim(input logic v, input logic [63:0] d, input logic [2:0] b,
                                    input logic l, input logic a, input logic r);
    stim_t s;
    s.v = v; s.d = d; s.b = b; s.l = l; s.a = a; s.r = r;
    return s;
  endfunction

  function automatic ev_t mk_ev(input logic [63:0] d, input logic [2:0] b, input logic l,
                                input logic a, input logic e, input logic [31:0] c);
    ev_t x;
    x.d = d; x.b = b; x.l = l; x.a = a; x.e = e; x.c = c;
    return x;
  endfunction

  // Bit-serial reflected CRC-32 reference; returns the complemented register.
  function automatic logic [31:0] crc_ref(input logic [7:0] b[$]);
    logic [31:0] c;
    c = 32'hffffffff;
    foreach (b[i])
      for (int k = 0; k < 8; k++)
        c = (c[0] ^ b[i][k]) ? ((c >> 1) ^ 32'hedb88320) : (c >> 1);
    return ~c;
  endfunction

  function automatic ev_t g_obs();
    return mk_ev(g_m_valid ? g_m_data : 64'h0, g_m_valid ? g_m_bytes : 3'h0,
                 g_m_valid && g_m_last, g_m_abort, g_err,
                 (g_m_valid && g_m_last) ? g_crc : 32'h0);
  endfunction

  function automatic ev_t c_obs();
    return mk_ev(c_m_valid ? c_m_data : 64'h0, c_m_valid ? c_m_bytes : 3'h0,
                 c_m_valid && c_m_last, c_m_abort, c_err,
                 (c_m_valid && c_m_last) ? c_crc : 32'h0);
  endfunction

  task automatic g_apply(input stim_t s);
    g_s_valid = s.v; g_s_data = s.d; g_s_bytes = s.b;
    g_s_last  = s.l; g_s_abort = s.a; rst = s.r;
  endtask

  task automatic c_apply(input stim_t s);
    c_s_valid = s.v; c_s_data = s.d; c_s_bytes = s.b;
    c_s_last  = s.l; c_s_abort = s.a;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({g_m_valid, g_m_abort, g_m_last, g_m_bytes, g_m_data, g_crc, g_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_gen: got v=%b a=%b l=%b b=%h d=%h crc=%h err=%b want all 0",
               g_m_valid, g_m_abort, g_m_last, g_m_bytes, g_m_data, g_crc, g_err);
    end
    n_checks++;
    if ({c_m_valid, c_m_abort, c_m_last, c_m_bytes, c_m_data, c_crc, c_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_chk: got v=%b a=%b l=%b b=%h d=%h crc=%h err=%b want all 0",
               c_m_valid, c_m_abort, c_m_last, c_m_bytes, c_m_data, c_crc, c_err);
    end
    rst = 1'b0;
  endtask

  task automatic test_golden;
    stim_t st[$];
    ev_t   e;
    st.push_back(mk_stim(1'b1, D1, 3'd5, 1'b0, 1'b0, 1'b0));
    g_q.push_back(mk_ev(D1, 3'd5, 1'b0, 1'b0, 1'b0, 32'h0));
    st.push_back(mk_stim(1'b1, D2, 3'd1, 1'b1, 1'b0, 1'b0));
    g_q.push_back(mk_ev(D2, 3'd1, 1'b1, 1'b0, 1'b0, Golden));
    repeat (2) st.push_back(mk_stim(1'b0, 64'h0, 3'h0, 1'b0, 1'b0, 1'b0));
    foreach (st[i]) begin
      g_apply(st[i]);
      @(negedge clk);
      if (g_m_valid || g_m_abort || g_err) begin
        n_checks++;
        if (g_q.size() == 0) begin
          n_fail++; $display("FAIL golden: unexpected output %h, want none", g_obs());
        end else begin
          e = g_q.pop_front();
          if (g_obs() !== e) begin
            n_fail++; $display("FAIL golden: got %h want %h", g_obs(), e);
          end
        end
      end
    end
    n_checks++;
    if (g_q.size() != 0) begin
      n_fail++; $display("FAIL golden: %0d outputs missing, want 0", g_q.size()); g_q.delete();
    end
  endtask

  task automatic test_mid_abort;
    stim_t st[$];
    ev_t   e;
    // Abort on the first beat of a packet: beat discarded, nothing sent downstream.
    st.push_back(mk_stim(1'b1, 64'hdead_beef_0000_0001, 3'h0, 1'b0, 1'b1, 1'b0));
    for (int i = 0; i < 3; i++) begin
      st.push_back(mk_stim(1'b1, 64'h1111_0000_0000_0000 + 64'(i), 3'h0, 1'b0, 1'b0, 1'b0));
      g_q.push_back(mk_ev(64'h1111_0000_0000_0000 + 64'(i), 3'h0, 1'b0, 1'b0, 1'b0, 32'h0));
    end
    st.push_back(mk_stim(1'b0, 64'h0, 3'h0, 1'b0, 1'b1, 1'b0));
    g_q.push_back(mk_ev(64'h0, 3'h0, 1'b0, 1'b1, 1'b0, 32'h0));
    st.push_back(mk_stim(1'b0, 64'h0, 3'h0, 1'b0, 1'b0, 1'b0));
    st.push_back(mk_stim(1'b1, D1, 3'h0, 1'b0, 1'b0, 1'b0));
    g_q.push_back(mk_ev(D1, 3'h0, 1'b0, 1'b0, 1'b0, 32'h0));
    st.push_back(mk_stim(1'b1, D2, 3'd1, 1'b1, 1'b0, 1'b0));
    g_q.push_back(mk_ev(D2, 3'd1, 1'b1, 1'b0, 1'b0, Golden));
    repeat (2) st.push_back(mk_stim(1'b0, 64'h0, 3'h0, 1'b0, 1'b0, 1'b0));
    foreach (st[i]) begin
      g_apply(st[i]);
      @(negedge clk);
      if (g_m_valid || g_m_abort || g_err) begin
        n_checks++;
        if (g_q.size() == 0) begin
          n_fail++; $display("FAIL mid_abort: unexpected output %h, want none", g_obs());
        end else begin
          e = g_q.pop_front();
          if (g_obs() !== e) begin
            n_fail++; $display("FAIL mid_abort: got %h want %h", g_obs(), e);
          end
        end
      end
    end
    n_checks++;
    if (g_q.size() != 0) begin
      n_fail++; $display("FAIL mid_abort: %0d outputs missing, want 0", g_q.size()); g_q.delete();
    end
  endtask

  task automatic test_reset_midpkt;
    stim_t st[$];
    ev_t   e;
    st.push_back(mk_stim(1'b1, 64'h2222_0000_0000_0001, 3'h0, 1'b0, 1'b0, 1'b0));
    g_q.push_back(mk_ev(64'h2222_0000_0000_0001, 3'h0, 1'b0, 1'b0, 1'b0, 32'h0));
    st.push_back(mk_stim(1'b1, 64'h2222_0000_0000_0002, 3'h0, 1'b0, 1'b0, 1'b1));
    repeat (2) st.push_back(mk_stim(1'b0, 64'h0, 3'h0, 1'b0, 1'b0, 1'b0));
    st.push_back(mk_stim(1'b1, D1, 3'h0, 1'b0, 1'b0, 1'b0));
    g_q.push_back(mk_ev(D1, 3'h0, 1'b0, 1'b0, 1'b0, 32'h0));
    st.push_back(mk_stim(1'b1, D2, 3'd1, 1'b1, 1'b0, 1'b0));
    g_q.push_back(mk_ev(D2, 3'd1, 1'b1, 1'b0, 1'b0, Golden));
    repeat (2) st.push_back(mk_stim(1'b0, 64'h0, 3'h0, 1'b0, 1'b0, 1'b0));
    foreach (st[i]) begin
      g_apply(st[i]);
      @(negedge clk);
      if (st[i].r) begin
        n_checks++;
        if ({g_m_valid, g_m_abort, g_m_last, g_m_bytes, g_m_data, g_crc, g_err} !== '0) begin
          n_fail++;
          $display("FAIL reset_midpkt_values: got v=%b a=%b l=%b b=%h d=%h crc=%h want all 0",
                   g_m_valid, g_m_abort, g_m_last, g_m_bytes, g_m_data, g_crc);
        end
      end
      if (g_m_valid || g_m_abort || g_err) begin
        n_checks++;
        if (g_q.size() == 0) begin
          n_fail++; $display("FAIL reset_midpkt: unexpected output %h, want none", g_obs());
        end else begin
          e = g_q.pop_front();
          if (g_obs() !== e) begin
            n_fail++; $display("FAIL reset_midpkt: got %h want %h", g_obs(), e);
          end
        end
      end
    end
    n_checks++;
    if (g_q.size() != 0) begin
      n_fail++; $display("FAIL reset_midpkt: %0d outputs missing, want 0", g_q.size());
      g_q.delete();
    end
  endtask

  // 60-byte frame plus FCS, optionally with byte 17 bit 3 flipped after the FCS is computed.
  task automatic test_check_frame(input bit corrupt);
    logic [7:0]  fb[$];
    logic [31:0] fcs;
    logic [63:0] d;
    stim_t       st[$];
    ev_t         e;
    for (int i = 0; i < 60; i++) fb.push_back(8'(i * 37 + 11));
    fcs = crc_ref(fb);
    for (int k = 0; k < 4; k++) fb.push_back(fcs[8*k +: 8]);
    if (corrupt) fb[17] = fb[17] ^ 8'h08;
    for (int j = 0; j < 8; j++) begin
      for (int k = 0; k < 8; k++) d[8*k +: 8] = fb[8*j+k];
      st.push_back(mk_stim(1'b1, d, 3'h0, j == 7, 1'b0, 1'b0));
      if (j < 7 || !corrupt) c_q.push_back(mk_ev(d, 3'h0, j == 7, 1'b0, 1'b0,
                                                 (j == 7) ? 32'h2144df1c : 32'h0));
      else c_q.push_back(mk_ev(64'h0, 3'h0, 1'b0, 1'b1, 1'b1, 32'h0));
    end
    repeat (3) st.push_back(mk_stim(1'b0, 64'h0, 3'h0, 1'b0, 1'b0, 1'b0));
    foreach (st[i]) begin
      c_apply(st[i]);
      @(negedge clk);
      if (c_m_valid || c_m_abort || c_err) begin
        n_checks++;
        if (c_q.size() == 0) begin
          n_fail++; $display("FAIL check_frame(%0d): unexpected output %h", corrupt, c_obs());
        end else begin
          e = c_q.pop_front();
          if (c_obs() !== e) begin
            n_fail++; $display("FAIL check_frame(%0d): got %h want %h", corrupt, c_obs(), e);
          end
        end
      end
    end
    n_checks++;
    if (c_q.size() != 0) begin
      n_fail++; $display("FAIL check_frame(%0d): %0d outputs missing", corrupt, c_q.size());
      c_q.delete();
    end
  endtask

  task automatic test_backpressure;
    logic [7:0]  pb[$];
    logic [31:0] crc;
    logic [63:0] d;
    stim_t       s;
    ev_t         saved, e;
    int          pkts, cycles, len;
    bit          acc, stalled, last;
    pkts = 0; cycles = 0; acc = 1'b0; stalled = 1'b0; saved = '0;
    while ((pkts < 1000 || bp_q.size() != 0 || g_q.size() != 0) && cycles < 90000) begin
      if (stalled) begin
        n_checks++;
        if (!g_m_valid || g_obs() !== saved) begin
          n_fail++; $display("FAIL stall_stable: got v=%b %h want v=1 %h", g_m_valid, g_obs(), saved);
        end
      end
      if (acc) void'(bp_q.pop_front());
      if (bp_q.size() == 0 && pkts < 1000) begin
        len = $urandom_range(1, 200);
        pb.delete();
        for (int i = 0; i < len; i++) pb.push_back(8'($urandom));
        crc = crc_ref(pb);
        for (int j = 0; j * 8 < len; j++) begin
          last = ((j + 1) * 8 >= len);
          d = {$urandom, $urandom};
          for (int k = 0; k < 8; k++) if (j * 8 + k < len) d[8*k +: 8] = pb[j*8+k];
          s = mk_stim(1'b1, d, last ? 3'(len % 8) : 3'($urandom), last, 1'b0, 1'b0);
          bp_q.push_back(s);
          g_q.push_back(mk_ev(d, s.b, last, 1'b0, 1'b0, last ? crc : 32'h0));
        end
        pkts++;
      end
      g_m_ready = ($urandom_range(0, 9) < 3);
      if (bp_q.size() != 0) g_apply(bp_q[0]);
      else g_apply(mk_stim(1'b0, 64'h0, 3'h0, 1'b0, 1'b0, 1'b0));
      #1;
      acc = g_s_valid && g_s_ready;
      if (g_m_valid && g_m_ready) begin
        n_checks++;
        if (g_q.size() == 0) begin
          n_fail++; $display("FAIL backpressure: unexpected beat %h", g_obs());
        end else begin
          e = g_q.pop_front();
          if (g_obs() !== e) begin
            n_fail++; $display("FAIL backpressure: got %h want %h", g_obs(), e);
          end
        end
      end
      if (g_m_abort || g_err) begin
        n_checks++; n_fail++;
        $display("FAIL backpressure_abort: got abort=%b err=%b want 0", g_m_abort, g_err);
      end
      stalled = g_m_valid && !g_m_ready;
      saved   = g_obs();
      @(negedge clk);
      cycles++;
    end
    n_checks++;
    if (cycles >= 90000 || g_q.size() != 0) begin
      n_fail++;
      $display("FAIL backpressure_done: got %0d pkts, %0d beats pending want 1000, 0",
               pkts, g_q.size());
      g_q.delete();
    end
    g_m_ready = 1'b1;
    g_apply(mk_stim(1'b0, 64'h0, 3'h0, 1'b0, 1'b0, 1'b0));
  endtask

  initial begin
    g_apply(mk_stim(1'b0, 64'h0, 3'h0, 1'b0, 1'b0, 1'b1));
    c_apply(mk_stim(1'b0, 64'h0, 3'h0, 1'b0, 1'b0, 1'b0));
    g_m_ready = 1'b1;
    c_m_ready = 1'b1;
    test_reset();
    test_golden();
    test_mid_abort();
    test_reset_midpkt();
    test_check_frame(1'b0);
    test_check_frame(1'b1);
    test_backpressure();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
